transmission_status_tracker: RTL and testbench

Status producer that sits directly upstream of the LED status controller and the PS-readable status bank. Tracks the transmission run state of the data generator: start/abort/completion, loop counting against a latched loop limit, FIFO overflow errors and FIFO high watermark. Packs all of this into the 7×32-bit status_regs_pl bus that downstream consumers read (reg0 bit1 = transmission active, reg0 bit0 = loop limit reached).

---
 rtl/status_regs_pkg.sv | 26 ++
 rtl/sat_counter32.sv | 36 +++
 rtl/transmission_status_tracker.sv | 155 +++++++++++++++
 tb/tb_transmission_status_tracker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/status_regs_pkg.sv
// Shared constants for the transmission status bank: FSM encodings, register indices and
// reg0 bit positions, also used by the LED controller and the PS readback path.
package status_regs_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StActive = 2'b01,
    StDone   = 2'b10
  } tx_state_e;

  localparam int unsigned NUM_STATUS_REGS = 7;

  localparam int unsigned REG_CTRL    = 0;
  localparam int unsigned REG_FRAMES  = 1;
  localparam int unsigned REG_TOTAL   = 2;
  localparam int unsigned REG_OVF_CNT = 3;
  localparam int unsigned REG_WMARK   = 4;
  localparam int unsigned REG_CYCLES  = 5;
  localparam int unsigned REG_ID      = 6;

  localparam int unsigned BIT_LIMIT  = 0;
  localparam int unsigned BIT_ACTIVE = 1;
  localparam int unsigned BIT_OVF    = 2;
  localparam int unsigned STATE_LSB  = 4;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit counter with synchronous clear, optional load and increment that saturates at all-ones.
module sat_counter32 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] count
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      // An event coinciding with the clear is the first one counted afterwards.
      count_d = {31'b0, inc};
    end else if (load) begin
      count_d = load_value;
    end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/transmission_status_tracker.sv
// Tracks generator run state (start/abort/loop completion), FIFO overflow and watermark, and
// packs everything into the 7x32-bit status bank read by the LED controller and the PS.
module transmission_status_tracker
  import status_regs_pkg::*;
#(
  parameter logic [15:0] VERSION_ID       = 16'h0001,
  parameter int unsigned FIFO_LEVEL_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ctrl_enable,
  input  logic [31:0]                 loop_limit,
  input  logic                        frame_done,
  input  logic                        fifo_overflow,
  input  logic [FIFO_LEVEL_WIDTH-1:0] fifo_level,
  input  logic                        clear_errors,
  output logic                        transmission_active,
  output logic                        loop_limit_reached,
  output logic [32*NUM_STATUS_REGS-1:0] status_regs_pl
);

  tx_state_e                   state_q, state_d;
  logic                        enable_q;
  logic                        start;
  logic [31:0]                 limit_q, limit_d;
  logic [31:0]                 frame_count_q, frame_count_d;
  logic [31:0]                 total_frames_q, total_frames_d;
  logic [31:0]                 run_cycles_q, run_cycles_d;
  logic [15:0]                 run_count_q, run_count_d;
  logic                        limit_reached_q, limit_reached_d;
  logic                        ovf_sticky_q, ovf_sticky_d;
  logic [FIFO_LEVEL_WIDTH-1:0] watermark_q, watermark_d;
  logic [31:0]                 overflow_count;
  logic [31:0]                 regs [NUM_STATUS_REGS];

  assign start = ctrl_enable & ~enable_q;

  always_comb begin
    state_d         = state_q;
    limit_d         = limit_q;
    frame_count_d   = frame_count_q;
    total_frames_d  = total_frames_q;
    run_cycles_d    = run_cycles_q;
    run_count_d     = run_count_q;
    limit_reached_d = limit_reached_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d         = StActive;
          limit_d         = loop_limit;
          frame_count_d   = '0;
          run_cycles_d    = '0;
          run_count_d     = run_count_q + 16'd1;
          limit_reached_d = 1'b0;
        end
      end
      StActive: begin
        run_cycles_d = run_cycles_q + 32'd1;
        if (frame_done) begin
          frame_count_d  = frame_count_q + 32'd1;
          total_frames_d = total_frames_q + 32'd1;
          // A completing frame takes priority over a simultaneous abort.
          if ((limit_q != '0) && (frame_count_d == limit_q)) begin
            state_d         = StDone;
            limit_reached_d = 1'b1;
          end else if (!ctrl_enable) begin
            state_d = StIdle;
          end
        end else if (!ctrl_enable) begin
          state_d = StIdle;
        end
      end
      StDone: begin
        if (!ctrl_enable) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ovf_sticky_d = clear_errors ? fifo_overflow : (ovf_sticky_q | fifo_overflow);
    if (clear_errors || (fifo_level > watermark_q)) begin
      watermark_d = fifo_level;
    end else begin
      watermark_d = watermark_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StIdle;
      enable_q        <= 1'b0;
      limit_q         <= '0;
      frame_count_q   <= '0;
      total_frames_q  <= '0;
      run_cycles_q    <= '0;
      run_count_q     <= '0;
      limit_reached_q <= 1'b0;
      ovf_sticky_q    <= 1'b0;
      watermark_q     <= '0;
    end else begin
      state_q         <= state_d;
      enable_q        <= ctrl_enable;
      limit_q         <= limit_d;
      frame_count_q   <= frame_count_d;
      total_frames_q  <= total_frames_d;
      run_cycles_q    <= run_cycles_d;
      run_count_q     <= run_count_d;
      limit_reached_q <= limit_reached_d;
      ovf_sticky_q    <= ovf_sticky_d;
      watermark_q     <= watermark_d;
    end
  end

  sat_counter32 u_overflow_count (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clear_errors),
    .inc        (fifo_overflow),
    .load       (1'b0),
    .load_value (32'd0),
    .count      (overflow_count)
  );

  // Bus is a pure repacking of flops, so it inherits their registered timing and async reset.
  always_comb begin
    for (int k = 0; k < NUM_STATUS_REGS; k++) begin
      regs[k] = '0;
    end
    regs[REG_CTRL][BIT_LIMIT]        = limit_reached_q;
    regs[REG_CTRL][BIT_ACTIVE]       = (state_q == StActive);
    regs[REG_CTRL][BIT_OVF]          = ovf_sticky_q;
    regs[REG_CTRL][STATE_LSB +: 2]   = state_q;
    regs[REG_FRAMES]                 = frame_count_q;
    regs[REG_TOTAL]                  = total_frames_q;
    regs[REG_OVF_CNT]                = overflow_count;
    regs[REG_WMARK]                  = 32'(watermark_q);
    regs[REG_CYCLES]                 = run_cycles_q;
    regs[REG_ID]                     = {VERSION_ID, run_count_q};
  end

  always_comb begin
    status_regs_pl = '0;
    for (int k = 0; k < NUM_STATUS_REGS; k++) begin
      status_regs_pl[32*k +: 32] = regs[k];
    end
  end

  assign transmission_active = (state_q == StActive);
  assign loop_limit_reached  = limit_reached_q;

endmodule

// File: tb/tb_transmission_status_tracker.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_transmission_status_tracker;

  logic         clk = 1'b0;
  logic         rstn;
  logic         ctrl_enable;
  logic [31:0]  loop_limit;
  logic         frame_done;
  logic         fifo_overflow;
  logic [15:0]  fifo_level;
  logic         clear_errors;
  logic         transmission_active;
  logic         loop_limit_reached;
  logic [223:0] status_regs_pl;

  logic         s_clr, s_inc, s_load;
  logic [31:0]  s_val, s_count;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state (spec-level quantities)
  int          m_state;  // 0 idle, 1 active, 2 done
  bit          m_en_d, m_llr, m_sticky;
  logic [31:0] m_limit, m_fc, m_total, m_cycles;
  longint      m_ovf;
  logic [15:0] m_runs, m_wm;

  always #5 clk = ~clk;

  transmission_status_tracker #(
    .VERSION_ID       (16'h0001),
    .FIFO_LEVEL_WIDTH (16)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .ctrl_enable         (ctrl_enable),
    .loop_limit          (loop_limit),
    .frame_done          (frame_done),
    .fifo_overflow       (fifo_overflow),
    .fifo_level          (fifo_level),
    .clear_errors        (clear_errors),
    .transmission_active (transmission_active),
    .loop_limit_reached  (loop_limit_reached),
    .status_regs_pl      (status_regs_pl)
  );

  sat_counter32 u_sat (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (s_clr),
    .inc        (s_inc),
    .load       (s_load),
    .load_value (s_val),
    .count      (s_count)
  );

  task automatic model_reset();
    m_state = 0; m_en_d = 0; m_llr = 0; m_sticky = 0;
    m_limit = 0; m_fc = 0; m_total = 0; m_cycles = 0;
    m_ovf = 0; m_runs = 0; m_wm = 0;
  endtask

  task automatic model_update();
    bit start;
    start = ctrl_enable && !m_en_d;
    if (m_state == 0) begin
      if (start) begin
        m_state = 1; m_limit = loop_limit; m_fc = 0; m_cycles = 0;
        m_runs = m_runs + 16'd1; m_llr = 0;
      end
    end else if (m_state == 1) begin
      m_cycles = m_cycles + 32'd1;
      if (frame_done) begin
        m_fc = m_fc + 32'd1;
        m_total = m_total + 32'd1;
        if (m_limit != 0 && m_fc == m_limit) begin
          m_state = 2; m_llr = 1;
        end else if (!ctrl_enable) begin
          m_state = 0;
        end
      end else if (!ctrl_enable) begin
        m_state = 0;
      end
    end else begin
      if (!ctrl_enable) m_state = 0;
    end
    m_en_d = ctrl_enable;
    if (clear_errors) begin
      m_sticky = fifo_overflow;
      m_ovf    = fifo_overflow ? 1 : 0;
      m_wm     = fifo_level;
    end else begin
      if (fifo_overflow) begin
        m_sticky = 1;
        if (m_ovf < 64'h0000_0000_FFFF_FFFF) m_ovf = m_ovf + 1;
      end
      if (fifo_level > m_wm) m_wm = fifo_level;
    end
  endtask

  function automatic logic [223:0] exp_bus();
    logic [31:0] r [7];
    logic [223:0] b;
    r[0] = {26'b0, 2'(m_state), 1'b0, m_sticky, (m_state == 1), m_llr};
    r[1] = m_fc;
    r[2] = m_total;
    r[3] = m_ovf[31:0];
    r[4] = {16'b0, m_wm};
    r[5] = m_cycles;
    r[6] = {16'h0001, m_runs};
    for (int k = 0; k < 7; k++) b[32*k +: 32] = r[k];
    return b;
  endfunction

  function automatic logic [31:0] reg_of(int k);
    return status_regs_pl[32*k +: 32];
  endfunction

  task automatic check_bus(string name);
    logic [225:0] act, exp;
    act = {status_regs_pl, transmission_active, loop_limit_reached};
    exp = {exp_bus(), (m_state == 1), m_llr};
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_bus("model_compare");
  endtask

  task automatic pulse_frame();
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; ctrl_enable = 1'b0; loop_limit = '0; frame_done = 1'b0;
    fifo_overflow = 1'b0; fifo_level = '0; clear_errors = 1'b0;
    s_clr = 1'b0; s_inc = 1'b0; s_load = 1'b0; s_val = '0;
    model_reset();
    #1;
    chk32("reset_reg0", reg_of(0), 32'h0);
    chk32("reset_reg6", reg_of(6), 32'h0001_0000);
    check_bus("reset_bus");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    cyc(); cyc();
    chk32("idle_active", {31'b0, transmission_active}, 32'h0);

    // Limited run of 3 frames, 10 cycles apart
    loop_limit = 32'd3; ctrl_enable = 1'b1;
    cyc();
    for (int k = 1; k <= 3; k++) begin
      repeat (9) cyc();
      pulse_frame();
      chk32("limit_frame_count", reg_of(1), 32'(k));
    end
    chk32("limit_done_reg0", reg_of(0), 32'h21);
    chk32("limit_run_cycles", reg_of(5), 32'd30);
    ctrl_enable = 1'b0;
    cyc();
    chk32("limit_idle_reg0", reg_of(0), 32'h01);

    // Unlimited run of 5 frames, then restart
    loop_limit = 32'd0; ctrl_enable = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      pulse_frame();
      cyc();
    end
    ctrl_enable = 1'b0;
    cyc();
    chk32("unlim_frames", reg_of(1), 32'd5);
    chk32("unlim_reg0", reg_of(0), 32'h0);
    ctrl_enable = 1'b1;
    cyc();
    chk32("restart_frames", reg_of(1), 32'd0);
    chk32("restart_runs", reg_of(6), 32'h0001_0003);
    chk32("restart_total", reg_of(2), 32'd8);

    // Abort coinciding with a non-completing frame, then a completing one
    ctrl_enable = 1'b0;
    cyc();
    loop_limit = 32'd2; ctrl_enable = 1'b1;
    cyc();
    frame_done = 1'b1; ctrl_enable = 1'b0;
    cyc();
    frame_done = 1'b0;
    chk32("abort_frames", reg_of(1), 32'd1);
    chk32("abort_reg0", reg_of(0), 32'h0);
    ctrl_enable = 1'b1;
    cyc();
    pulse_frame();
    cyc();
    frame_done = 1'b1; ctrl_enable = 1'b0;
    cyc();
    frame_done = 1'b0;
    chk32("limit_wins_reg0", reg_of(0), 32'h21);
    chk32("limit_wins_frames", reg_of(1), 32'd2);
    cyc();
    chk32("limit_wins_idle", reg_of(0), 32'h01);

    // Overflow and watermark
    fifo_level = 16'd10;
    cyc();
    fifo_level = 16'd300; fifo_overflow = 1'b1;
    cyc();
    fifo_level = 16'd40;
    cyc(); cyc();
    fifo_overflow = 1'b0;
    cyc();
    chk32("ovf_count", reg_of(3), 32'd3);
    chk32("ovf_wmark", reg_of(4), 32'd300);
    chk32("ovf_sticky", {31'b0, reg_of(0)[2]}, 32'd1);
    clear_errors = 1'b1; fifo_overflow = 1'b1;
    cyc();
    clear_errors = 1'b0; fifo_overflow = 1'b0;
    chk32("clr_count", reg_of(3), 32'd1);
    chk32("clr_wmark", reg_of(4), 32'd40);
    chk32("clr_sticky", {31'b0, reg_of(0)[2]}, 32'd1);

    // Saturation of the overflow counter primitive
    s_load = 1'b1; s_val = 32'hFFFF_FFFE;
    cyc();
    s_load = 1'b0; s_inc = 1'b1;
    cyc();
    chk32("sat_first", s_count, 32'hFFFF_FFFF);
    cyc(); cyc();
    chk32("sat_hold", s_count, 32'hFFFF_FFFF);
    s_clr = 1'b1;
    cyc();
    s_clr = 1'b0; s_inc = 1'b0;
    chk32("sat_clr_inc", s_count, 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) ctrl_enable = ~ctrl_enable;
      loop_limit    = 32'($urandom_range(0, 6));
      frame_done    = ($urandom_range(0, 2) == 0);
      fifo_overflow = ($urandom_range(0, 9) == 0);
      clear_errors  = ($urandom_range(0, 49) == 0);
      fifo_level    = 16'($urandom);
      cyc();
    end
    frame_done = 1'b0; fifo_overflow = 1'b0; clear_errors = 1'b0;

    // Asynchronous reset in the middle of an active run
    loop_limit = 32'd0; ctrl_enable = 1'b0;
    cyc();
    ctrl_enable = 1'b1;
    cyc();
    pulse_frame();
    cyc();
    chk32("pre_reset_active", {31'b0, transmission_active}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_bus("async_reset_bus");
    chk32("async_reset_reg0", reg_of(0), 32'h0);
    chk32("async_reset_reg6", reg_of(6), 32'h0001_0000);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    cyc();
    chk32("enable_through_reset", reg_of(0), 32'h12);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
